// File: rtl/mult_arbiter_5.sv
// Round-robin arbiter that shares one external multiplier among N_REQ requesters.
// Each operation runs IDLE -> ISSUE -> WAIT -> DONE, with a bounded wait on mul_rdy.
module mult_arbiter_5 #(
  parameter int N_REQ   = 4,
  parameter int OPW     = 9,
  parameter int PRW     = 17,
  parameter int TIMEOUT = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_REQ-1:0]     req,
  input  logic [N_REQ*OPW-1:0] a_in,
  input  logic [N_REQ*OPW-1:0] b_in,
  output logic [N_REQ-1:0]     gnt,
  output logic [PRW-1:0]       res_out,
  output logic [N_REQ-1:0]     res_vld,
  output logic [N_REQ-1:0]     err,
  output logic                 busy,
  output logic [OPW-1:0]       mul_a,
  output logic [OPW-1:0]       mul_b,
  output logic                 mul_start,
  input  logic [PRW-1:0]       mul_prdct,
  input  logic                 mul_rdy
);

  localparam int PTRW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNTW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [PTRW-1:0]  PTR_RST  = PTRW'(N_REQ - 1);
  localparam logic [CNTW-1:0]  CNT_LAST = CNTW'(TIMEOUT - 1);
  localparam logic [N_REQ-1:0] ONE_HOT0 = N_REQ'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [PTRW-1:0]  ptr_q, ptr_d;
  logic [CNTW-1:0]  cnt_q, cnt_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic             start_q, start_d;
  logic [OPW-1:0]   mul_a_q, mul_a_d;
  logic [OPW-1:0]   mul_b_q, mul_b_d;
  logic [PRW-1:0]   res_q, res_d;
  logic [N_REQ-1:0] res_vld_q, res_vld_d;
  logic [N_REQ-1:0] err_q, err_d;
  logic [PTRW-1:0]  win_s;

  // Search starts one past the last winner so every requester gets a turn.
  function automatic logic [PTRW-1:0] rr_pick(input logic [N_REQ-1:0] r,
                                              input logic [PTRW-1:0]  p);
    logic [PTRW-1:0] pick;
    logic            found;
    int              idx;
    pick  = p;
    found = 1'b0;
    for (int off = 1; off <= N_REQ; off++) begin
      idx = (int'(p) + off) % N_REQ;
      if (!found && r[PTRW'(idx)]) begin
        pick  = PTRW'(idx);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ptr_q     <= PTR_RST;
      cnt_q     <= '0;
      gnt_q     <= '0;
      start_q   <= 1'b0;
      mul_a_q   <= '0;
      mul_b_q   <= '0;
      res_q     <= '0;
      res_vld_q <= '0;
      err_q     <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      gnt_q     <= gnt_d;
      start_q   <= start_d;
      mul_a_q   <= mul_a_d;
      mul_b_q   <= mul_b_d;
      res_q     <= res_d;
      res_vld_q <= res_vld_d;
      err_q     <= err_d;
    end
  end

  // Next-state and next-output logic; pulses default low, held values default to hold.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    gnt_d     = '0;
    start_d   = 1'b0;
    mul_a_d   = mul_a_q;
    mul_b_d   = mul_b_q;
    res_d     = res_q;
    res_vld_d = '0;
    err_d     = '0;
    win_s     = rr_pick(req, ptr_q);
    case (state_q)
      IDLE: begin
        if (|req) begin
          state_d = ISSUE;
          ptr_d   = win_s;
          gnt_d   = ONE_HOT0 << win_s;
          start_d = 1'b1;
          mul_a_d = a_in[int'(win_s)*OPW +: OPW];
          mul_b_d = b_in[int'(win_s)*OPW +: OPW];
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        state_d = WAIT;
        cnt_d   = '0;
      end
      WAIT: begin
        // A product arriving on the expiry cycle still counts as a result.
        if (mul_rdy) begin
          state_d   = DONE;
          res_d     = mul_prdct;
          res_vld_d = ONE_HOT0 << ptr_q;
        end else if (cnt_q == CNT_LAST) begin
          state_d = DONE;
          res_d   = '0;
          err_d   = ONE_HOT0 << ptr_q;
        end else begin
          cnt_d = cnt_q + CNTW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign gnt       = gnt_q;
  assign mul_start = start_q;
  assign mul_a     = mul_a_q;
  assign mul_b     = mul_b_q;
  assign res_out   = res_q;
  assign res_vld   = res_vld_q;
  assign err       = err_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mult_arbiter_5.sv
// Randomized scoreboard bench for mult_arbiter_5: a driver predicts grants and results
// from round-robin/timeout rules, a monitor pops and compares when the DUT pulses.
module tb_mult_arbiter_5;
  localparam int N   = 4;
  localparam int OPW = 9;
  localparam int PRW = 17;
  localparam int TO  = 32;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   req = '0;
  logic [N*OPW-1:0] a_in = '0, b_in = '0;
  logic [N-1:0]   gnt, res_vld, err;
  logic [PRW-1:0] res_out;
  logic           busy, mul_start;
  logic [OPW-1:0] mul_a, mul_b;
  logic [PRW-1:0] mul_prdct = '0;
  logic           mul_rdy = 1'b0;

  mult_arbiter_5 #(.N_REQ(N), .OPW(OPW), .PRW(PRW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .a_in(a_in), .b_in(b_in),
    .gnt(gnt), .res_out(res_out), .res_vld(res_vld), .err(err), .busy(busy),
    .mul_a(mul_a), .mul_b(mul_b), .mul_start(mul_start),
    .mul_prdct(mul_prdct), .mul_rdy(mul_rdy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int idx; logic [OPW-1:0] a; logic [OPW-1:0] b; int cyc; } gnt_t;
  typedef struct { int idx; bit is_err; logic [PRW-1:0] val; int cyc; } res_t;

  gnt_t gq[$];
  res_t rq[$];
  int checks = 0;
  int errors = 0;

  bit             pend[N];
  logic [OPW-1:0] pa[N], pb[N];
  int             last_win = N - 1;
  int             prev_res_cyc = -100;
  logic [PRW-1:0] res_model = '0;
  logic [OPW-1:0] cur_a = '0, cur_b = '0;

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  function automatic logic [63:0] all_outs();
    return 64'({gnt, res_vld, err, busy, mul_start, mul_a, mul_b, res_out});
  endfunction

  task automatic drive_req();
    for (int i = 0; i < N; i++) begin
      req[i] = pend[i];
      a_in[i*OPW +: OPW] = pa[i];
      b_in[i*OPW +: OPW] = pb[i];
    end
  endtask

  task automatic new_op(input int i);
    pend[i] = 1'b1;
    pa[i] = OPW'($urandom);
    pb[i] = OPW'($urandom);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // mode 0: random new requests, 1: all requesting, 2: none added.
  // cont 0: random, 1: winner keeps requesting, 2: winner drops.
  // lat >= 0: mul_rdy after lat WAIT cycles; -1: never; -2: reset during WAIT.
  task automatic do_round(input int mode, input int cont, input int lat);
    int c, w, k, gc, idx;
    bit got, any;
    gnt_t g;
    res_t r;
    logic signed [PRW-1:0] prod;
    any = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!pend[i] && (mode == 1 || (mode == 0 && $urandom_range(0, 1) == 1))) new_op(i);
      any |= pend[i];
    end
    if (!any) new_op($urandom_range(0, N - 1));
    drive_req();
    c = cyc;
    w = -1;
    for (int off = 1; off <= N; off++) begin
      idx = (last_win + off) % N;
      if (w < 0 && pend[idx]) w = idx;
    end
    gc = (c + 1 > prev_res_cyc + 2) ? c + 1 : prev_res_cyc + 2;
    g.idx = w; g.a = pa[w]; g.b = pb[w]; g.cyc = gc;
    gq.push_back(g);
    last_win = w;
    prod = $signed(pa[w]) * $signed(pb[w]);
    r.idx = w;
    if (lat >= 0 && lat <= TO - 1) begin
      r.is_err = 1'b0; r.val = prod; r.cyc = gc + 2 + lat;
    end else begin
      r.is_err = 1'b1; r.val = '0; r.cyc = gc + TO + 1;
    end
    rq.push_back(r);
    pend[w] = 1'b0;

    got = 1'b0;
    for (k = 0; k < 8 && !got; k++) begin
      tick();
      if (gnt !== '0) got = 1'b1;
    end
    if (!got) begin
      chk("gnt_wait_expired", 64'd0, 64'd1);
      return;
    end
    if ($urandom_range(0, 3) == 0) begin
      mul_rdy = 1'b1;
      mul_prdct = PRW'($urandom);
    end
    tick();
    mul_rdy = 1'b0;
    chk("busy_in_wait", 64'(busy), 64'd1);
    if (cont == 1 || (cont == 0 && $urandom_range(0, 1) == 1)) new_op(w);
    drive_req();

    if (lat == -2) begin
      repeat (3) tick();
      rst_n = 1'b0;
      #1;
      chk("reset_in_wait_outputs", all_outs(), 64'd0);
      void'(rq.pop_back());
      for (int i = 0; i < N; i++) pend[i] = 1'b0;
      drive_req();
      res_model = '0;
      last_win = N - 1;
      prev_res_cyc = -100;
      tick();
      rst_n = 1'b1;
      tick();
      mul_rdy = 1'b1;
      mul_prdct = PRW'($urandom);
      tick();
      mul_rdy = 1'b0;
      tick();
      chk("post_reset_quiet", all_outs(), 64'd0);
      return;
    end
    if (lat >= 0) begin
      repeat (lat) tick();
      mul_rdy = 1'b1;
      mul_prdct = prod;
      tick();
      mul_rdy = 1'b0;
      mul_prdct = PRW'($urandom);
    end
    got = 1'b0;
    for (k = 0; k < TO + 8 && !got; k++) begin
      if (res_vld !== '0 || err !== '0) got = 1'b1;
      else tick();
    end
    if (!got) chk("done_wait_expired", 64'd0, 64'd1);
    prev_res_cyc = cyc;
  endtask

  // Monitor: pops the scoreboard whenever the DUT pulses gnt or a result.
  initial begin
    gnt_t g;
    res_t r;
    logic [N-1:0] oh;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (gnt !== '0 || mul_start !== 1'b0) begin
          if (gq.size() == 0) begin
            chk("unexpected_gnt", 64'({gnt, mul_start}), 64'd0);
          end else begin
            g = gq.pop_front();
            oh = '0;
            oh[g.idx] = 1'b1;
            chk("gnt", 64'(gnt), 64'(oh));
            chk("mul_start", 64'(mul_start), 64'd1);
            chk("gnt_cycle", 64'(cyc), 64'(g.cyc));
            chk("busy_in_issue", 64'(busy), 64'd1);
            cur_a = g.a;
            cur_b = g.b;
          end
        end
        if (res_vld !== '0 || err !== '0) begin
          if (rq.size() == 0) begin
            chk("unexpected_result", 64'({res_vld, err}), 64'd0);
          end else begin
            r = rq.pop_front();
            oh = '0;
            oh[r.idx] = 1'b1;
            chk("res_vld", 64'(res_vld), r.is_err ? 64'd0 : 64'(oh));
            chk("err", 64'(err), r.is_err ? 64'(oh) : 64'd0);
            chk("result_cycle", 64'(cyc), 64'(r.cyc));
            res_model = r.val;
          end
        end
        chk("res_out", 64'(res_out), 64'(res_model));
        if (busy === 1'b1) begin
          chk("mul_a_held", 64'(mul_a), 64'(cur_a));
          chk("mul_b_held", 64'(mul_b), 64'(cur_b));
        end
      end
    end
  end

  // Stimulus: directed cases, then randomized rounds, then reset recovery.
  initial begin
    int sel, lat;
    logic [PRW-1:0] hold;
    for (int i = 0; i < N; i++) begin
      pend[i] = 1'b0; pa[i] = '0; pb[i] = '0;
    end
    #2;
    chk("reset_outputs", all_outs(), 64'd0);
    tick();
    rst_n = 1'b1;

    pend[2] = 1'b1; pa[2] = 9'h012; pb[2] = 9'h034;
    do_round(2, 2, 0);
    chk("single_res_out", 64'(res_out), 64'h003A8);
    tick();
    chk("single_busy_low", 64'(busy), 64'd0);

    hold = res_model;
    mul_rdy = 1'b1;
    mul_prdct = 17'h1ABCD;
    tick();
    mul_rdy = 1'b0;
    tick();
    chk("spurious_rdy_busy", 64'(busy), 64'd0);
    chk("spurious_rdy_res", 64'(res_out), 64'(hold));

    pend[1] = 1'b1; pa[1] = OPW'($urandom); pb[1] = OPW'($urandom);
    do_round(2, 2, -1);
    do_round(2, 2, TO - 1);

    for (int n = 0; n < 60; n++) begin
      sel = $urandom_range(0, 9);
      if (sel <= 5) lat = $urandom_range(0, 3);
      else if (sel == 6) lat = TO - 1;
      else if (sel == 7) lat = TO - 2;
      else if (sel == 8) lat = -1;
      else lat = $urandom_range(4, TO - 3);
      do_round(0, 0, lat);
    end

    do_round(1, 0, 1);
    do_round(2, 2, -2);
    for (int n = 0; n < 5; n++) do_round(1, 1, 0);
    for (int i = 0; i < N; i++) pend[i] = 1'b0;
    drive_req();
    repeat (4) tick();
    chk("gnt_queue_drained", 64'(gq.size()), 64'd0);
    chk("res_queue_drained", 64'(rq.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
